// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin multiplexing scheduler.
//   NUM_REQ : number of requester lanes (16)
//   SEL_W   : width of a requester index (4)
//   state_t : scheduler FSM states
//   onehot  : index -> one-hot grant vector
package mux_sched_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// rr_pick: combinational round-robin search.
// Ports:
//   req   (in)  : per-requester request bits
//   ptr   (in)  : index searched first; search continues ptr+1, ... mod 16
//   found (out) : at least one request bit is set
//   idx   (out) : first requesting index at or after ptr (ptr when none)
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    always_comb begin
        logic [SEL_W-1:0] w_cand;
        found  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        // Walk from the farthest offset back to ptr so the nearest hit is
        // the last one written and therefore wins.
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            w_cand = ptr + SEL_W'(k - 1);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: 16-lane round-robin burst scheduler feeding one
// valid/ready output. A granted requester keeps the output for up to
// MAX_BURST transfers or until it drops its request, then the grant
// rotates to the next requester with no idle cycle in between.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester request, bit i = requester i
//   data_in   : 16 lanes, lane i at [i*DATA_W +: DATA_W]
//   out_ready : consumer accepts out_data this cycle
//   out_valid : BUSY and the granted requester still requests
//   out_data  : data_in lane sel
//   sel       : registered granted index
//   gnt       : registered one-hot grant, zero when idle
//   busy      : FSM is in BUSY
module mux_rr_scheduler
    import mux_sched_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          sel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy
);

    state_t             r_state, w_state_nxt;
    logic [SEL_W-1:0]   r_ptr, w_ptr_nxt;
    logic [3:0]         r_burst_cnt, w_burst_nxt;
    logic [SEL_W-1:0]   r_sel, w_sel_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;

    logic               w_req_sel;
    logic               w_xfer;
    logic               w_last;
    logic               w_release;
    logic [SEL_W-1:0]   w_arb_ptr;
    logic               w_found;
    logic [SEL_W-1:0]   w_idx;

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign busy      = (r_state == BUSY);
    assign out_data  = data_in[r_sel*DATA_W +: DATA_W];

    assign w_req_sel = req[r_sel];
    assign out_valid = busy && w_req_sel;
    assign w_xfer    = out_valid && out_ready;
    assign w_last    = (r_burst_cnt == 4'(MAX_BURST - 1));
    assign w_release = busy && ((w_xfer && w_last) || !w_req_sel);

    // On release the search already starts past the current owner, so the
    // regrant happens in the same cycle and the owner drops to lowest priority.
    assign w_arb_ptr = w_release ? (r_sel + SEL_W'(1)) : r_ptr;

    rr_pick u_pick (
        .req   (req),
        .ptr   (w_arb_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst_cnt;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_sel_nxt   = w_idx;
                    w_gnt_nxt   = onehot(w_idx);
                    w_burst_nxt = '0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_ptr_nxt   = w_arb_ptr;
                    w_burst_nxt = '0;
                    if (w_found) begin
                        w_sel_nxt = w_idx;
                        w_gnt_nxt = onehot(w_idx);
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_xfer) begin
                    w_burst_nxt = r_burst_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_burst_cnt <= '0;
            r_sel       <= '0;
            r_gnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

endmodule
